// File: rtl/elevator_car_if.sv
// Controller <-> car port: motion/door commands and cab buttons in, position and status out.
interface elevator_car_if #(
  parameter int unsigned FLOORS = 5
) ();
  logic              up;
  logic              down;
  logic              door;
  logic [FLOORS-1:0] cab_btn;
  logic [2:0]        floor;
  logic              moving;
  logic              door_open;
  logic              arrive;
  logic [FLOORS-1:0] cab_req;

  // Controller side drives commands and observes the car.
  modport master (
    output up, down, door, cab_btn,
    input  floor, moving, door_open, arrive, cab_req
  );

  // Car side responds to commands and reports status.
  modport slave (
    input  up, down, door, cab_btn,
    output floor, moving, door_open, arrive, cab_req
  );
endinterface

// File: rtl/elevator_car.sv
// Cab-side model of one elevator car: single-floor moves, door sequencing,
// latched in-cab requests and status reporting back to the controller.
module elevator_car #(
  parameter int unsigned FLOORS        = 5,
  parameter int unsigned TRAVEL_CYCLES = 4,
  parameter int unsigned DOOR_CYCLES   = 3
) (
  input logic           clk,
  input logic           reset,
  elevator_car_if.slave bus
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] MOVE_UP   = 2'd1;
  localparam logic [1:0] MOVE_DN   = 2'd2;
  localparam logic [1:0] DOOR_OPEN = 2'd3;

  localparam int unsigned       CNT_W       = 8;
  localparam logic [CNT_W-1:0]  TRAVEL_LOAD = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0]  DOOR_LOAD   = CNT_W'(DOOR_CYCLES - 1);
  localparam logic [2:0]        TOP_FLOOR   = 3'(FLOORS - 1);
  localparam logic [FLOORS-1:0] FLOOR_ONE   = FLOORS'(1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        floor_q, floor_d;
  logic              arrive_q, arrive_d;
  logic              moving_q, door_open_q;
  logic [FLOORS-1:0] cab_req_q, cab_req_d;
  logic [FLOORS-1:0] clr;

  // State, timer, position and request registers; everything clears at once on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      floor_q     <= '0;
      arrive_q    <= 1'b0;
      moving_q    <= 1'b0;
      door_open_q <= 1'b0;
      cab_req_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      floor_q     <= floor_d;
      arrive_q    <= arrive_d;
      moving_q    <= (state_d == MOVE_UP) || (state_d == MOVE_DN);
      door_open_q <= (state_d == DOOR_OPEN);
      cab_req_q   <= cab_req_d;
    end
  end

  // Next-state, timer and floor logic; request clear for the floor whose door is opening.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    floor_d  = floor_q;
    arrive_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.door) begin
          state_d = DOOR_OPEN;
          cnt_d   = DOOR_LOAD;
        end else if (bus.up && !bus.down && (floor_q < TOP_FLOOR)) begin
          state_d = MOVE_UP;
          cnt_d   = TRAVEL_LOAD;
        end else if (bus.down && !bus.up && (floor_q != 3'd0)) begin
          state_d = MOVE_DN;
          cnt_d   = TRAVEL_LOAD;
        end
      end
      MOVE_UP, MOVE_DN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          floor_d  = (state_q == MOVE_UP) ? floor_q + 3'd1 : floor_q - 3'd1;
          arrive_d = 1'b1;
          state_d  = IDLE;
        end
      end
      DOOR_OPEN: begin
        if (bus.door) begin
          cnt_d = DOOR_LOAD;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    clr       = (state_d == DOOR_OPEN) ? (FLOOR_ONE << floor_q) : '0;
    cab_req_d = (cab_req_q | bus.cab_btn) & ~clr;
  end

  assign bus.floor     = floor_q;
  assign bus.moving    = moving_q;
  assign bus.door_open = door_open_q;
  assign bus.arrive    = arrive_q;
  assign bus.cab_req   = cab_req_q;

endmodule
